// File: rtl/cache_arb_pkg.sv
// Shared types for the I/D cacheline arbiter: FSM states, requester ids and
// the mapping from a winning requester to its grant state.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GNT_I,
        ARB_GNT_D,
        ARB_RECOVER
    } arb_state_t;

    typedef enum logic {
        SRC_I,
        SRC_D
    } arb_src_t;

    function automatic arb_state_t grant_state(input arb_src_t src);
        return (src == SRC_D) ? ARB_GNT_D : ARB_GNT_I;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way requester pick (fixed D priority or round-robin) plus the
// last-grant flop that steers round-robin ties.
module rr_arb2
    import cache_arb_pkg::*;
#(
    parameter int D_PRIORITY = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_req,
    input  logic     d_req,
    input  logic     grant_en,
    output logic     pick_valid,
    output arb_src_t pick_src
);

    arb_src_t last_grant_reg;

    always_comb begin
        pick_valid = i_req | d_req;
        pick_src   = SRC_I;
        if (i_req && d_req) begin
            if (D_PRIORITY != 0) begin
                pick_src = SRC_D;
            end else begin
                // Round-robin: the requester that did not win last time goes next.
                pick_src = (last_grant_reg == SRC_I) ? SRC_D : SRC_I;
            end
        end else if (d_req) begin
            pick_src = SRC_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= SRC_I;
        end else if (grant_en && pick_valid) begin
            last_grant_reg <= pick_src;
        end
    end

endmodule

// File: rtl/cacheline_arbiter.sv
// Serialises I-cache line reads and D-cache line reads/writebacks onto the single
// cacheline adaptor port, one transaction at a time with a recovery cycle between.
module cacheline_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 256,
    parameter int D_PRIORITY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_resp
);

    arb_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] m_address_reg;
    logic [LINE_W-1:0] m_wdata_reg;
    logic              m_read_reg, m_write_reg;
    logic              pick_valid;
    arb_src_t          pick_src;
    logic              grant;
    logic              d_is_write;

    rr_arb2 #(
        .D_PRIORITY(D_PRIORITY)
    ) u_rr_arb2 (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_read),
        .d_req     (d_read | d_write),
        .grant_en  (state_reg == ARB_IDLE),
        .pick_valid(pick_valid),
        .pick_src  (pick_src)
    );

    assign grant      = (state_reg == ARB_IDLE) && pick_valid;
    assign d_is_write = (pick_src == SRC_D) && d_write;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE:    if (pick_valid) state_next = grant_state(pick_src);
            ARB_GNT_I,
            ARB_GNT_D:   if (m_resp) state_next = ARB_RECOVER;
            ARB_RECOVER: state_next = ARB_IDLE;
            default:     state_next = ARB_IDLE;
        endcase
    end

    // The m_* registers are loaded only at grant, so requester changes mid-transaction
    // never reach the adaptor.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ARB_IDLE;
            m_address_reg <= '0;
            m_wdata_reg   <= '0;
            m_read_reg    <= 1'b0;
            m_write_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                m_address_reg <= (pick_src == SRC_D) ? d_address : i_address;
                m_wdata_reg   <= d_wdata;
                m_read_reg    <= ~d_is_write;
                m_write_reg   <= d_is_write;
            end else if ((state_reg == ARB_GNT_I || state_reg == ARB_GNT_D) && m_resp) begin
                m_read_reg  <= 1'b0;
                m_write_reg <= 1'b0;
            end
        end
    end

    assign m_address = m_address_reg;
    assign m_wdata   = m_wdata_reg;
    assign m_read    = m_read_reg;
    assign m_write   = m_write_reg;

    assign i_resp  = (state_reg == ARB_GNT_I) && m_resp;
    assign d_resp  = (state_reg == ARB_GNT_D) && m_resp;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(d_read && d_write));
            assert (!(m_resp && (state_reg == ARB_IDLE || state_reg == ARB_RECOVER)));
        end
    end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed bench for cacheline_arbiter: one fixed-priority and one round-robin
// instance share all inputs; each task checks its scenario inline.
module tb_cacheline_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_address, d_address;
    logic         i_read, d_read, d_write;
    logic [255:0] d_wdata, m_rdata;
    logic         m_resp;

    logic [255:0] i_rdata, d_rdata, m_wdata;
    logic         i_resp, d_resp, m_read, m_write;
    logic [31:0]  m_address;

    logic [255:0] rr_i_rdata, rr_d_rdata, rr_m_wdata;
    logic         rr_i_resp, rr_d_resp, rr_m_read, rr_m_write;
    logic [31:0]  rr_m_address;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    cacheline_arbiter #(.ADDR_W(32), .LINE_W(256), .D_PRIORITY(1)) dut (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_resp(m_resp)
    );

    cacheline_arbiter #(.ADDR_W(32), .LINE_W(256), .D_PRIORITY(0)) dut_rr (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read), .i_rdata(rr_i_rdata), .i_resp(rr_i_resp),
        .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(rr_d_rdata), .d_resp(rr_d_resp),
        .m_address(rr_m_address), .m_read(rr_m_read), .m_write(rr_m_write),
        .m_wdata(rr_m_wdata), .m_rdata(m_rdata), .m_resp(m_resp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; m_resp = 1'b0;
        i_address = '0; d_address = '0; d_wdata = '0; m_rdata = '0;
        tick(); tick();
        compared++;
        if ({m_read, m_write, i_resp, d_resp} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_ctrl: got rd/wr/iresp/dresp=%b want 0000",
                     {m_read, m_write, i_resp, d_resp});
        end
        compared++;
        if ({m_address, m_wdata} !== {32'h0, 256'h0}) begin
            mismatched++;
            $display("FAIL reset_data: got addr=%h wdata=%h want 0", m_address, m_wdata);
        end
        rst = 1'b0;
        tick();
        $display("txn reset done");
    endtask

    task automatic test_i_read();
        logic [255:0] line;
        line = {8{32'h1234_5678}};
        i_address = 32'h0000_1000; i_read = 1'b1;
        tick();
        compared++;
        if ({m_read, m_write, m_address} !== {1'b1, 1'b0, 32'h0000_1000}) begin
            mismatched++;
            $display("FAIL i_read_start: got rd=%b wr=%b addr=%h want 1 0 00001000",
                     m_read, m_write, m_address);
        end
        tick(); tick(); tick();
        compared++;
        if ({m_read, i_resp} !== 2'b10) begin
            mismatched++;
            $display("FAIL i_read_hold: got rd=%b iresp=%b want 1 0", m_read, i_resp);
        end
        m_rdata = line; m_resp = 1'b1;
        #1;
        compared++;
        if ({i_resp, d_resp, i_rdata} !== {1'b1, 1'b0, line}) begin
            mismatched++;
            $display("FAIL i_read_resp: got iresp=%b dresp=%b rdata=%h want 1 0 %h",
                     i_resp, d_resp, i_rdata, line);
        end
        tick();
        m_resp = 1'b0; i_read = 1'b0;
        #1;
        compared++;
        if ({m_read, i_resp} !== 2'b00) begin
            mismatched++;
            $display("FAIL i_read_end: got rd=%b iresp=%b want 0 0", m_read, i_resp);
        end
        tick();
        $display("txn i_read addr=00001000 done");
    endtask

    task automatic test_d_write();
        logic [255:0] a5;
        a5 = {32{8'hA5}};
        d_address = 32'h0000_2040; d_wdata = a5; d_write = 1'b1;
        tick();
        compared++;
        if ({m_read, m_write, m_address, m_wdata} !== {1'b0, 1'b1, 32'h0000_2040, a5}) begin
            mismatched++;
            $display("FAIL d_write_start: got rd=%b wr=%b addr=%h wdata=%h", m_read, m_write,
                     m_address, m_wdata);
        end
        d_wdata = {32{8'h3C}}; d_address = 32'h0000_FFC0;
        tick(); tick();
        compared++;
        if ({m_write, m_address, m_wdata, d_resp} !== {1'b1, 32'h0000_2040, a5, 1'b0}) begin
            mismatched++;
            $display("FAIL d_write_hold: got wr=%b addr=%h wdata=%h dresp=%b want held A5 line",
                     m_write, m_address, m_wdata, d_resp);
        end
        m_resp = 1'b1;
        #1;
        compared++;
        if ({d_resp, i_resp} !== 2'b10) begin
            mismatched++;
            $display("FAIL d_write_resp: got dresp=%b iresp=%b want 1 0", d_resp, i_resp);
        end
        tick();
        m_resp = 1'b0; d_write = 1'b0;
        #1;
        compared++;
        if ({m_write, d_resp} !== 2'b00) begin
            mismatched++;
            $display("FAIL d_write_end: got wr=%b dresp=%b want 0 0", m_write, d_resp);
        end
        tick();
        $display("txn d_write addr=00002040 done");
    endtask

    task automatic test_tie_priority();
        logic [255:0] line;
        line = {8{32'hCAFE_F00D}};
        i_address = 32'h0000_3000; i_read = 1'b1;
        d_address = 32'h0000_4000; d_read = 1'b1;
        tick();
        compared++;
        if ({m_read, m_write, m_address} !== {1'b1, 1'b0, 32'h0000_4000}) begin
            mismatched++;
            $display("FAIL tie_first_d: got rd=%b wr=%b addr=%h want 1 0 00004000",
                     m_read, m_write, m_address);
        end
        m_rdata = line; m_resp = 1'b1;
        #1;
        compared++;
        if ({d_resp, i_resp, d_rdata} !== {1'b1, 1'b0, line}) begin
            mismatched++;
            $display("FAIL tie_d_resp: got dresp=%b iresp=%b rdata=%h", d_resp, i_resp, d_rdata);
        end
        tick();
        m_resp = 1'b0; d_read = 1'b0;
        tick();
        compared++;
        if ({m_read, i_resp} !== 2'b00) begin
            mismatched++;
            $display("FAIL tie_wait: got rd=%b iresp=%b want 0 0 (I still waiting)",
                     m_read, i_resp);
        end
        tick();
        compared++;
        if ({m_read, m_address} !== {1'b1, 32'h0000_3000}) begin
            mismatched++;
            $display("FAIL tie_second_i: got rd=%b addr=%h want 1 00003000", m_read, m_address);
        end
        m_resp = 1'b1;
        #1;
        compared++;
        if ({i_resp, d_resp} !== 2'b10) begin
            mismatched++;
            $display("FAIL tie_i_resp: got iresp=%b dresp=%b want 1 0", i_resp, d_resp);
        end
        tick();
        m_resp = 1'b0; i_read = 1'b0;
        tick();
        $display("txn tie D then I done");
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr [4];
        logic        exp_d    [4];
        exp_addr = '{32'h0000_6000, 32'h0000_5000, 32'h0000_6000, 32'h0000_5000};
        exp_d    = '{1'b1, 1'b0, 1'b1, 1'b0};
        i_address = 32'h0000_5000; i_read = 1'b1;
        d_address = 32'h0000_6000; d_read = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            compared++;
            if ({rr_m_read, rr_m_address} !== {1'b1, exp_addr[t]}) begin
                mismatched++;
                $display("FAIL rr_grant_%0d: got rd=%b addr=%h want 1 %h", t, rr_m_read,
                         rr_m_address, exp_addr[t]);
            end
            m_resp = 1'b1;
            #1;
            compared++;
            if ({rr_d_resp, rr_i_resp} !== {exp_d[t], ~exp_d[t]}) begin
                mismatched++;
                $display("FAIL rr_resp_%0d: got dresp=%b iresp=%b want %b %b", t, rr_d_resp,
                         rr_i_resp, exp_d[t], ~exp_d[t]);
            end
            tick();
            m_resp = 1'b0;
            tick();
            $display("txn rr %0d src=%s addr=%h", t, exp_d[t] ? "D" : "I", exp_addr[t]);
        end
        i_read = 1'b0; d_read = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        d_address = 32'h0000_7000; d_wdata = {8{32'h0BAD_BEEF}}; d_write = 1'b1;
        tick();
        compared++;
        if (m_write !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_start: got wr=%b want 1", m_write);
        end
        tick();
        rst = 1'b1; d_write = 1'b0;
        tick();
        rst = 1'b0;
        compared++;
        if ({m_write, m_read, d_resp, m_address, m_wdata} !== {3'b000, 32'h0, 256'h0}) begin
            mismatched++;
            $display("FAIL abort_cleared: got wr=%b rd=%b dresp=%b addr=%h", m_write, m_read,
                     d_resp, m_address);
        end
        i_address = 32'h0000_8000; i_read = 1'b1;
        tick();
        compared++;
        if ({m_read, m_address} !== {1'b1, 32'h0000_8000}) begin
            mismatched++;
            $display("FAIL abort_new_i: got rd=%b addr=%h want 1 00008000", m_read, m_address);
        end
        m_resp = 1'b1;
        #1;
        compared++;
        if ({i_resp, d_resp} !== 2'b10) begin
            mismatched++;
            $display("FAIL abort_i_resp: got iresp=%b dresp=%b want 1 0", i_resp, d_resp);
        end
        tick();
        m_resp = 1'b0; i_read = 1'b0;
        tick();
        $display("txn reset abort then i_read addr=00008000 done");
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        d_address = 32'h0000_9000; d_read = 1'b1;
        tick();
        m_resp = 1'b1;
        #1;
        if (d_resp === 1'b1) pulses++;
        tick();
        m_resp = 1'b0;
        #1;
        if (d_resp === 1'b1) pulses++;
        compared++;
        if (m_read !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_resp_plus1: got rd=%b want 0", m_read);
        end
        tick();
        if (d_resp === 1'b1) pulses++;
        compared++;
        if (m_read !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_resp_plus2: got rd=%b want 0", m_read);
        end
        compared++;
        if (pulses !== 1) begin
            mismatched++;
            $display("FAIL b2b_pulses: got %0d d_resp pulses want 1", pulses);
        end
        tick();
        compared++;
        if ({m_read, m_address} !== {1'b1, 32'h0000_9000}) begin
            mismatched++;
            $display("FAIL b2b_restart: got rd=%b addr=%h want 1 00009000", m_read, m_address);
        end
        m_resp = 1'b1;
        #1;
        tick();
        m_resp = 1'b0; d_read = 1'b0;
        tick();
        $display("txn back-to-back d_read addr=00009000 done");
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_tie_priority();
        test_round_robin();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
